// File: rtl/serial_word_deserializer_pkg.sv
// Shared types and constants for the serial word deserializer.
package deser_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_PARITY
  } deser_state_t;

  localparam logic START_BIT = 1'b1;
  localparam int   DEF_WIDTH = 8;

endpackage

// File: rtl/serial_word_deserializer_if.sv
// Serial-in / word-out handshake bundle. Optional parity_err under DESER_PARITY_EN.
interface serial_word_deserializer_if
  import deser_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             bit_in;
  logic             bit_en;
  logic             out_ready;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             overrun;
  logic             busy;
`ifdef DESER_PARITY_EN
  logic             parity_err;
`endif

  modport master (
    output bit_in, bit_en, out_ready,
`ifdef DESER_PARITY_EN
    input  parity_err,
`endif
    input  word_out, word_valid, overrun, busy
  );

  modport slave (
    input  bit_in, bit_en, out_ready,
`ifdef DESER_PARITY_EN
    output parity_err,
`endif
    output word_out, word_valid, overrun, busy
  );

endinterface

// File: rtl/serial_word_deserializer_shift.sv
// Plain MSB-first shift register with asynchronous clear.
module serial_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else if (shift_en) begin
      q_q <= {q_q[WIDTH-2:0], bit_in};
    end
  end

  assign q = q_q;

endmodule

// File: rtl/serial_word_deserializer.sv
// Frame assembler: start bit, WIDTH data bits MSB-first, optional even parity
// bit when DESER_PARITY_EN is defined; words leave over a valid/ready register.
module serial_word_deserializer
  import deser_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic                 clk,
  input logic                 rst_n,
  serial_word_deserializer_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  deser_state_t     state_q;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_next;
  logic [WIDTH-1:0] word_d;
  logic [WIDTH-1:0] word_out_q;
  logic             word_valid_q;
  logic             overrun_q;
  logic             commit_d;
  logic             shift_en;
  logic             last_bit;
`ifdef DESER_PARITY_EN
  logic             perr_d;
  logic             perr_q;
`else
  // Without a parity stage the oldest bit falls off in the commit cycle.
  logic             unused_msb;
  assign unused_msb = shift_q[WIDTH-1];
`endif

  assign shift_en   = bus.bit_en && (state_q == S_SHIFT);
  assign shift_next = {shift_q[WIDTH-2:0], bus.bit_in};
  assign last_bit   = (count_q == CNT_W'(WIDTH - 1));

  serial_shift_reg #(.WIDTH(WIDTH)) u_shift (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (shift_en),
    .bit_in   (bus.bit_in),
    .q        (shift_q)
  );

  always_comb begin
    commit_d = 1'b0;
    word_d   = shift_next;
`ifdef DESER_PARITY_EN
    perr_d   = 1'b0;
    if (bus.bit_en && state_q == S_PARITY) begin
      commit_d = 1'b1;
      word_d   = shift_q;
      perr_d   = ^{shift_q, bus.bit_in};
    end
`else
    if (bus.bit_en && state_q == S_SHIFT && last_bit) begin
      commit_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      word_out_q   <= '0;
      word_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef DESER_PARITY_EN
      perr_q       <= 1'b0;
`endif
    end else begin
      if (bus.bit_en) begin
        case (state_q)
          S_IDLE: begin
            if (bus.bit_in == START_BIT) begin
              state_q <= S_SHIFT;
              count_q <= '0;
            end
          end
          S_SHIFT: begin
            count_q <= count_q + CNT_W'(1);
            if (last_bit) begin
`ifdef DESER_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_IDLE;
`endif
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end

      // A full, unaccepted output register drops the new word and flags it.
      if (commit_d) begin
        if (!word_valid_q || bus.out_ready) begin
          word_out_q   <= word_d;
          word_valid_q <= 1'b1;
`ifdef DESER_PARITY_EN
          perr_q       <= perr_d;
`endif
        end else begin
          overrun_q    <= 1'b1;
        end
      end else if (word_valid_q && bus.out_ready) begin
        word_valid_q <= 1'b0;
      end
    end
  end

  assign bus.word_out   = word_out_q;
  assign bus.word_valid = word_valid_q;
  assign bus.overrun    = overrun_q;
  assign bus.busy       = (state_q != S_IDLE);
`ifdef DESER_PARITY_EN
  assign bus.parity_err = perr_q;
`endif

endmodule
